// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter in front of one shared FP multiplier, two-stage result path.
// Optional MUL_ARB_FIXED_PRIO_EN: requester 0 gets absolute priority over the rest.
module fp_mul_arbiter #(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [N_REQ-1:0]    req_valid,
   input  logic [32*N_REQ-1:0] req_a,
   input  logic [32*N_REQ-1:0] req_b,
   output logic [N_REQ-1:0]    req_ready,
   output logic                res_valid,
   output logic [31:0]         res_data,
   output logic [ID_W-1:0]     res_id,
   input  logic                res_ready
);

`ifdef MUL_ARB_FIXED_PRIO_EN
   localparam logic SKIP0 = 1'b1;
`else
   localparam logic SKIP0 = 1'b0;
`endif

   localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

   logic [31:0]     op_a;
   logic [31:0]     op_b;
   logic [ID_W-1:0] op_id;
   logic            s1_full;
   logic [ID_W-1:0] rr_ptr;
   logic [ID_W-1:0] win_id;
   logic [ID_W-1:0] cand;
   logic            win_vld;
   logic            s2_free;
   logic            s1_adv;
   logic            s1_free;
   logic            hs;
   logic [31:0]     win_a;
   logic [31:0]     win_b;

   function automatic logic [31:0] fmul(input logic [31:0] a,
                                        input logic [31:0] b);
      logic [47:0] p;
      logic [7:0]  e;
      logic [22:0] m;
      if (a[30:0] == 31'd0 || b[30:0] == 31'd0)
         return 32'd0;
      p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
      e = a[30:23] + b[30:23] - 8'd127 + {7'd0, p[47]};
      m = p[47] ? p[46:24] : p[45:23];
      return {a[31] ^ b[31], e, m};
   endfunction

   assign s2_free = ~res_valid | res_ready;
   assign s1_adv  = s1_full & s2_free;
   assign s1_free = ~s1_full | s1_adv;

   // Search starts just after the last winner; requester 0 may be pinned first.
   always_comb begin
      win_vld = 1'b0;
      win_id  = '0;
      cand    = '0;
      if (SKIP0 && req_valid[0]) begin
         win_vld = 1'b1;
      end
      for (int k = 1; k <= N_REQ; k++) begin
         cand = ID_W'((int'(rr_ptr) + k) % N_REQ);
         if (!win_vld && req_valid[cand] &&
             !(SKIP0 && cand == '0)) begin
            win_vld = 1'b1;
            win_id  = cand;
         end
      end
   end

   assign req_ready = (rst_n && s1_free && win_vld) ?
                      (ONE << win_id) : '0;
   assign hs    = |(req_ready & req_valid);
   assign win_a = req_a[32*win_id +: 32];
   assign win_b = req_b[32*win_id +: 32];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_a      <= '0;
         op_b      <= '0;
         op_id     <= '0;
         s1_full   <= 1'b0;
         rr_ptr    <= ID_W'(N_REQ - 1);
         res_valid <= 1'b0;
         res_data  <= '0;
         res_id    <= '0;
      end else begin
         if (hs) begin
            op_a    <= win_a;
            op_b    <= win_b;
            op_id   <= win_id;
            s1_full <= 1'b1;
            if (!(SKIP0 && win_id == '0))
               rr_ptr <= win_id;
         end else if (s1_adv) begin
            s1_full <= 1'b0;
         end
         if (s1_adv) begin
            res_data  <= fmul(op_a, op_b);
            res_id    <= op_id;
            res_valid <= 1'b1;
         end else if (res_ready) begin
            res_valid <= 1'b0;
         end
      end
   end

endmodule
